// File: rtl/ternary_dot_feeder.sv
// Streams 128 ternary weights + 128 activation bits as 48 bytes to the dot core, waits WAIT_CYCLES, then captures the 13-bit result.
// Result valid at T+49+WAIT_CYCLES after start; result held in DONE until result_ready, start ignored while busy.
module ternary_dot_feeder #(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] w_data,
    input  logic [127:0] a_data,
    output logic         busy,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    output logic         tx_last,
    input  logic [7:0]   core_lo,
    input  logic [4:0]   core_hi,
    output logic [15:0]  result,
    output logic         result_valid,
    input  logic         result_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [5:0] LAST_BYTE = 6'd47;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t       state;
    state_t       state_nxt;
    logic [5:0]   byte_cnt;
    logic [3:0]   wait_cnt;
    logic [255:0] w_shadow;
    logic [127:0] a_shadow;
    logic [255:0] w_clean;
    logic [15:0]  result_q;

    // Invalid code 10 folds to 00: high bit survives only when the low bit is also set.
    always_comb begin
        w_clean = w_data;
        for (int i = 0; i < 128; i++) begin
            w_clean[2*i+1] = w_data[2*i+1] & w_data[2*i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = (state != S_IDLE);
        result_valid = (state == S_DONE);
        tx_valid     = 1'b0;
        tx_last      = 1'b0;
        tx_data      = 8'h00;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                tx_valid = 1'b1;
                tx_last  = (byte_cnt == LAST_BYTE);
                // Bytes 0..31 carry weights, 32..47 carry activations.
                if (byte_cnt[5]) begin
                    tx_data = a_shadow[{byte_cnt[3:0], 3'b000} +: 8];
                end else begin
                    tx_data = w_shadow[{byte_cnt[4:0], 3'b000} +: 8];
                end
                if (byte_cnt == LAST_BYTE) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 6'd0;
            wait_cnt <= 4'd0;
            w_shadow <= '0;
            a_shadow <= '0;
            result_q <= 16'h0000;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        w_shadow <= w_clean;
                        a_shadow <= a_data;
                        byte_cnt <= 6'd0;
                    end
                end
                S_STREAM: begin
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt <= 6'd0;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        byte_cnt <= byte_cnt + 6'd1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        result_q <= {{3{core_hi[4]}}, core_hi, core_lo};
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ternary_dot_feeder.sv
// Randomised bench for ternary_dot_feeder against a stream/result model built from element-level weight values.
module tb_ternary_dot_feeder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] w_data;
    logic [127:0] a_data;
    logic         busy;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_last;
    logic [7:0]   core_lo;
    logic [4:0]   core_hi;
    logic [15:0]  result;
    logic         result_valid;
    logic         result_ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] got_bytes[$];
    int         got_cyc[$];
    int         got_last[$];
    int         rv_cycle;
    int         busy_drop;
    logic [7:0] exp_bytes[48];

    ternary_dot_feeder #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .start(start), .w_data(w_data), .a_data(a_data),
        .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .core_lo(core_lo), .core_hi(core_hi), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    // Decode each weight to -1/0/+1, re-encode canonically, then lay out bytes.
    function automatic void build_model(input logic [255:0] w, input logic [127:0] a);
        logic [255:0] enc;
        int wt;
        enc = '0;
        for (int i = 0; i < 128; i++) begin
            case (w[2*i +: 2])
                2'b01:   wt = 1;
                2'b11:   wt = -1;
                default: wt = 0;
            endcase
            enc[2*i +: 2] = (wt == 1) ? 2'b01 : (wt == -1) ? 2'b11 : 2'b00;
        end
        for (int k = 0; k < 32; k++) exp_bytes[k] = enc[8*k +: 8];
        for (int k = 0; k < 16; k++) exp_bytes[32+k] = a[8*k +: 8];
    endfunction

    function automatic logic [15:0] sext13(input logic [12:0] c);
        int v;
        v = int'(c);
        if (v >= 4096) v = v - 8192;
        return v[15:0];
    endfunction

    function automatic logic [7:0] got_at(input int k);
        return (k < got_bytes.size()) ? got_bytes[k] : 8'hxx;
    endfunction

    // Pulses start, records every streamed byte with its cycle offset, stops at first result_valid.
    task automatic collect(input int repulse);
        got_bytes.delete(); got_cyc.delete(); got_last.delete();
        rv_cycle  = -1;
        busy_drop = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 200 && rv_cycle < 0; n++) begin
            if (tx_valid) begin
                got_bytes.push_back(tx_data);
                got_cyc.push_back(n);
                if (tx_last) got_last.push_back(n);
            end
            if (!busy) busy_drop++;
            if (result_valid) rv_cycle = n;
            else begin
                start = (n == repulse);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic rand_inputs();
        for (int j = 0; j < 8; j++) w_data[32*j +: 32] = $urandom;
        for (int j = 0; j < 4; j++) a_data[32*j +: 32] = $urandom;
        core_hi = 5'($urandom);
        core_lo = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, tx_valid, tx_last, tx_data, result, result_valid} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b txv=%b txl=%b txd=%h res=%h rv=%b want all 0",
                     busy, tx_valid, tx_last, tx_data, result, result_valid);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        w_data = {128{2'b01}};
        a_data = '1;
        core_hi = 5'h00; core_lo = 8'h80;
        build_model(w_data, a_data);
        collect(0);
        vectors++;
        if (got_bytes.size() != 48) begin
            miscompares++; $display("FAIL basic_count got %0d want 48", got_bytes.size());
        end
        for (int k = 0; k < 48; k++) begin
            vectors++;
            if (got_at(k) !== exp_bytes[k] || (k < got_cyc.size() && got_cyc[k] != k + 1)) begin
                miscompares++;
                $display("FAIL basic_byte%0d got %h want %h (cycle want T+%0d)", k, got_at(k), exp_bytes[k], k + 1);
            end
        end
        vectors++;
        if (got_last.size() != 1 || got_last[0] != 48) begin
            miscompares++; $display("FAIL basic_last got %0d marks want one at T+48", got_last.size());
        end
        vectors++;
        if (rv_cycle != 49 + W || busy_drop != 0) begin
            miscompares++; $display("FAIL basic_rv_time got T+%0d busy_drop=%0d want T+%0d", rv_cycle, busy_drop, 49 + W);
        end
        vectors++;
        if (result !== 16'h0080) begin
            miscompares++; $display("FAIL basic_result got %h want 0080", result);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || tx_valid !== 1'b0 || result !== 16'h0080) begin
            miscompares++;
            $display("FAIL basic_accept got busy=%b rv=%b txv=%b res=%h want 0 0 0 0080", busy, result_valid, tx_valid, result);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] exp_res;
        for (int p = 0; p < 9; p++) begin
            rand_inputs();
            if (p == 0) begin
                w_data = {128{2'b01}}; a_data = '1; core_hi = 5'h1F; core_lo = 8'h80;
            end else if (p == 1) begin
                core_hi = 5'h0F; core_lo = 8'hFF;
            end else if (p == 2) begin
                w_data = {128{2'b10}}; a_data = {16{8'hAA}};
            end
            build_model(w_data, a_data);
            exp_res = sext13({core_hi, core_lo});
            collect(0);
            vectors++;
            if (got_bytes.size() != 48 || got_last.size() != 1 || rv_cycle != 49 + W) begin
                miscompares++;
                $display("FAIL pat%0d_shape got bytes=%0d lasts=%0d rv=T+%0d want 48 1 T+%0d",
                         p, got_bytes.size(), got_last.size(), rv_cycle, 49 + W);
            end
            for (int k = 0; k < 48; k++) begin
                vectors++;
                if (got_at(k) !== exp_bytes[k]) begin
                    miscompares++; $display("FAIL pat%0d_byte%0d got %h want %h", p, k, got_at(k), exp_bytes[k]);
                end
            end
            vectors++;
            if (result !== exp_res) begin
                miscompares++; $display("FAIL pat%0d_result got %h want %h", p, result, exp_res);
            end
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        rand_inputs();
        build_model(w_data, a_data);
        collect(10);
        vectors++;
        if (got_bytes.size() != 48 || rv_cycle != 49 + W || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ign_stream got bytes=%0d rv=T+%0d busy=%b want 48 T+%0d 1", got_bytes.size(), rv_cycle, busy, 49 + W);
        end
        result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        result_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            miscompares++; $display("FAIL ign_accept got busy=%b rv=%b want 0 0", busy, result_valid);
        end
        extra = 0;
        for (int n = 0; n < 70; n++) begin
            if (tx_valid || busy || result_valid) extra++;
            @(negedge clk);
        end
        vectors++;
        if (extra != 0) begin
            miscompares++; $display("FAIL ign_no_second_txn got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_res;
        rand_inputs();
        core_lo = 8'h5A;
        exp_res = sext13({core_hi, core_lo});
        collect(0);
        vectors++;
        if (rv_cycle != 49 + W || result !== exp_res) begin
            miscompares++; $display("FAIL bp_first got rv=T+%0d res=%h want T+%0d %h", rv_cycle, result, 49 + W, exp_res);
        end
        for (int n = 0; n < 20; n++) begin
            core_hi = 5'($urandom);
            core_lo = 8'($urandom);
            @(negedge clk);
            vectors++;
            if (result_valid !== 1'b1 || result !== exp_res) begin
                miscompares++; $display("FAIL bp_hold%0d got rv=%b res=%h want 1 %h", n, result_valid, result, exp_res);
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
            miscompares++; $display("FAIL bp_accept got rv=%b busy=%b res=%h want 0 0 %h", result_valid, busy, result, exp_res);
        end
    endtask

    task automatic test_reset_mid();
        rand_inputs();
        build_model(w_data, a_data);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== exp_bytes[20]) begin
            miscompares++; $display("FAIL rstmid_byte20 got v=%b %h want 1 %h", tx_valid, tx_data, exp_bytes[20]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0000 || result_valid !== 1'b0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_clear got txv=%b busy=%b res=%h rv=%b txd=%h want all 0", tx_valid, busy, result, result_valid, tx_data);
        end
        rand_inputs();
        build_model(w_data, a_data);
        collect(0);
        vectors++;
        if (got_bytes.size() != 48 || got_cyc.size() == 0 || got_cyc[0] != 1 || rv_cycle != 49 + W) begin
            miscompares++; $display("FAIL rstmid_restart got bytes=%0d rv=T+%0d want 48 T+%0d", got_bytes.size(), rv_cycle, 49 + W);
        end
        for (int k = 0; k < 48; k++) begin
            vectors++;
            if (got_at(k) !== exp_bytes[k]) begin
                miscompares++; $display("FAIL rstmid_byte%0d got %h want %h", k, got_at(k), exp_bytes[k]);
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; result_ready = 1'b0;
        w_data = '0; a_data = '0; core_lo = 8'h00; core_hi = 5'h00;
        test_reset();
        test_basic();
        test_patterns();
        test_start_ignored();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
